// File: rtl/ram_pkg.sv
// Shared definitions for the RAM burst controller: default widths and FSM state encoding.
package ram_pkg;

    localparam int DEF_ADDR_WIDTH = 6;
    localparam int DEF_DATA_WIDTH = 6;

    typedef logic [1:0] state_t;

    localparam state_t ST_INIT  = 2'd0;
    localparam state_t ST_IDLE  = 2'd1;
    localparam state_t ST_WRITE = 2'd2;
    localparam state_t ST_READ  = 2'd3;

endpackage

// File: rtl/ram_addr_gen.sv
// Burst address generator: loadable wrapping address plus a down-counting beat counter.
module ram_addr_gen
    import ram_pkg::*;
#(
    parameter int addr_width = DEF_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_load,
    input  logic [addr_width-1:0] i_load_addr,
    input  logic [addr_width:0]   i_load_cnt,
    input  logic                  i_incr,
    output logic [addr_width-1:0] o_addr,
    output logic [addr_width-1:0] o_addr_next,
    output logic                  o_last
);

    // One extra count bit so a full-depth burst (2**addr_width beats) fits.
    localparam logic [addr_width:0] C_DEPTH = {1'b1, {addr_width{1'b0}}};
    localparam logic [addr_width:0] C_ONE   = {{addr_width{1'b0}}, 1'b1};

    logic [addr_width-1:0] r_addr;
    logic [addr_width:0]   r_cnt;

    // Reset preloads a full-depth sweep from address 0 for the post-reset clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr <= '0;
            r_cnt  <= C_DEPTH;
        end else if (i_load) begin
            r_addr <= i_load_addr;
            r_cnt  <= i_load_cnt;
        end else if (i_incr) begin
            r_addr <= r_addr + 1'b1;
            r_cnt  <= r_cnt - 1'b1;
        end
    end

    assign o_addr      = r_addr;
    assign o_addr_next = r_addr + 1'b1;
    assign o_last      = (r_cnt == C_ONE);

endmodule

// File: rtl/ram_burst_ctrl.sv
// Burst read/write controller for a single-port synchronous RAM, with a full clear after reset.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_INIT  | write 0 to every address, one per cycle
// ST_IDLE  | cmd_ready=1, waiting for a burst command
// ST_WRITE | wr_ready=1, one RAM write per accepted write beat
// ST_READ  | stream RAM data out; first cycle primes the RAM read port
module ram_burst_ctrl
    import ram_pkg::*;
#(
    parameter int addr_width = DEF_ADDR_WIDTH,
    parameter int data_width = DEF_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [addr_width-1:0] cmd_addr,
    input  logic [addr_width-1:0] cmd_len,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [data_width-1:0] wr_data,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic [data_width-1:0] rd_data,
    output logic                  busy,
    output logic                  init_done,
    output logic                  ram_we,
    output logic [addr_width-1:0] ram_addr,
    output logic [data_width-1:0] ram_data_in,
    input  logic [data_width-1:0] ram_data_out
);

    state_t r_state;
    logic   r_init_done;
    logic   r_rd_valid;

    logic [addr_width-1:0] w_addr;
    logic [addr_width-1:0] w_addr_next;
    logic [addr_width:0]   w_load_cnt;
    logic                  w_last;
    logic                  w_accept;
    logic                  w_wr_beat;
    logic                  w_rd_beat;
    logic                  w_incr;

    assign w_accept   = (r_state == ST_IDLE) && cmd_valid;
    assign w_wr_beat  = (r_state == ST_WRITE) && wr_valid;
    assign w_rd_beat  = (r_state == ST_READ) && r_rd_valid && rd_ready;
    assign w_incr     = (r_state == ST_INIT) || w_wr_beat || w_rd_beat;
    assign w_load_cnt = {1'b0, cmd_len} + 1'b1;

    ram_addr_gen #(
        .addr_width (addr_width)
    ) u_addr_gen (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_load      (w_accept),
        .i_load_addr (cmd_addr),
        .i_load_cnt  (w_load_cnt),
        .i_incr      (w_incr),
        .o_addr      (w_addr),
        .o_addr_next (w_addr_next),
        .o_last      (w_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_INIT;
            r_init_done <= 1'b0;
            r_rd_valid  <= 1'b0;
        end else begin
            case (r_state)
                ST_INIT: begin
                    if (w_last) begin
                        r_state     <= ST_IDLE;
                        r_init_done <= 1'b1;
                    end
                end
                ST_IDLE: begin
                    r_rd_valid <= 1'b0;
                    if (cmd_valid) begin
                        r_state <= cmd_write ? ST_WRITE : ST_READ;
                    end
                end
                ST_WRITE: begin
                    if (wr_valid && w_last) begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_READ: begin
                    if (!r_rd_valid) begin
                        r_rd_valid <= 1'b1;
                    end else if (rd_ready && w_last) begin
                        r_rd_valid <= 1'b0;
                        r_state    <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_INIT;
                end
            endcase
        end
    end

    // Reset gates the write strobe directly so an aborted burst cannot write during reset.
    assign ram_we      = rst_n && ((r_state == ST_INIT) || w_wr_beat);
    assign ram_data_in = w_wr_beat ? wr_data : '0;
    // On a read handshake, look ahead one address so the next beat is ready after the edge.
    assign ram_addr    = w_rd_beat ? w_addr_next : w_addr;

    assign cmd_ready = (r_state == ST_IDLE);
    assign wr_ready  = (r_state == ST_WRITE);
    assign rd_valid  = r_rd_valid;
    assign rd_data   = ram_data_out;
    assign busy      = (r_state != ST_IDLE);
    assign init_done = r_init_done;

endmodule

// File: tb/tb_ram_burst_ctrl.sv
// Directed testbench for ram_burst_ctrl with a behavioural synchronous RAM attached.
module tb_ram_burst_ctrl;

    logic       clk;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_write;
    logic [5:0] cmd_addr;
    logic [5:0] cmd_len;
    logic       wr_valid;
    logic       wr_ready;
    logic [5:0] wr_data;
    logic       rd_valid;
    logic       rd_ready;
    logic [5:0] rd_data;
    logic       busy;
    logic       init_done;
    logic       ram_we;
    logic [5:0] ram_addr;
    logic [5:0] ram_data_in;
    logic [5:0] ram_data_out;

    int checks = 0;
    int errors = 0;

    logic [5:0] mem [64];
    logic [5:0] r_raddr;
    logic       fill;
    logic [5:0] vec [64];

    ram_burst_ctrl #(
        .addr_width (6),
        .data_width (6)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_write    (cmd_write),
        .cmd_addr     (cmd_addr),
        .cmd_len      (cmd_len),
        .wr_valid     (wr_valid),
        .wr_ready     (wr_ready),
        .wr_data      (wr_data),
        .rd_valid     (rd_valid),
        .rd_ready     (rd_ready),
        .rd_data      (rd_data),
        .busy         (busy),
        .init_done    (init_done),
        .ram_we       (ram_we),
        .ram_addr     (ram_addr),
        .ram_data_in  (ram_data_in),
        .ram_data_out (ram_data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model: registered read address, write on we; fill seeds non-zero junk.
    always @(posedge clk) begin
        if (fill) begin
            for (int i = 0; i < 64; i++) mem[i] <= 6'h2A;
        end else if (ram_we) begin
            mem[ram_addr] <= ram_data_in;
        end
        r_raddr <= ram_addr;
    end
    assign ram_data_out = mem[r_raddr];

    task automatic test_reset();
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_len   = '0;
        wr_valid  = 1'b0;
        wr_data   = '0;
        rd_ready  = 1'b0;
        fill      = 1'b1;
        repeat (2) @(posedge clk);
        fill = 1'b0;
        @(negedge clk);
        checks++;
        if (ram_we !== 1'b0 || ram_addr !== 6'd0 || ram_data_in !== 6'd0) begin
            errors++;
            $display("FAIL reset_ram_port: got we=%b addr=%0d din=%0d expected we=0 addr=0 din=0",
                     ram_we, ram_addr, ram_data_in);
        end
        checks++;
        if (cmd_ready !== 1'b0 || wr_ready !== 1'b0 || rd_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_handshake: got cmd_ready=%b wr_ready=%b rd_valid=%b expected 0 0 0",
                     cmd_ready, wr_ready, rd_valid);
        end
        checks++;
        if (busy !== 1'b1 || init_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_status: got busy=%b init_done=%b expected busy=1 init_done=0",
                     busy, init_done);
        end
    endtask

    // Releases reset and follows the clear sweep until init_done.
    task automatic test_init();
        int n;
        int bad;
        int zeros_bad;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n   = 0;
        bad = 0;
        for (int i = 0; i < 200; i++) begin
            if (init_done === 1'b1) break;
            if (ram_we === 1'b1) begin
                if (ram_addr !== n[5:0] || ram_data_in !== 6'd0) bad++;
                n++;
            end
            @(negedge clk);
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL init_sequence: got %0d out-of-order/non-zero writes expected 0", bad);
        end
        checks++;
        if (n != 64) begin
            errors++;
            $display("FAIL init_count: got %0d write cycles expected 64", n);
        end
        checks++;
        if (init_done !== 1'b1 || cmd_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL init_idle: got init_done=%b cmd_ready=%b busy=%b expected 1 1 0",
                     init_done, cmd_ready, busy);
        end
        zeros_bad = 0;
        for (int i = 0; i < 64; i++) if (mem[i] !== 6'd0) zeros_bad++;
        checks++;
        if (zeros_bad != 0) begin
            errors++;
            $display("FAIL init_clear: got %0d non-zero locations expected 0", zeros_bad);
        end
    endtask

    task automatic do_cmd(input logic w, input logic [5:0] a, input logic [5:0] l);
        int t;
        t = 0;
        cmd_write = w;
        cmd_addr  = a;
        cmd_len   = l;
        cmd_valid = 1'b1;
        while (cmd_ready !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL cmd_accept: got cmd_ready=%b expected 1 within 50 cycles", cmd_ready);
        end
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic test_write(input logic [5:0] a, input logic [5:0] l, input logic gap);
        int bad;
        logic [5:0] ea;
        do_cmd(1'b1, a, l);
        if (gap) begin
            wr_valid = 1'b0;
            @(negedge clk);
            checks++;
            if (ram_we !== 1'b0 || wr_ready !== 1'b1 || busy !== 1'b1) begin
                errors++;
                $display("FAIL write_gap: got we=%b wr_ready=%b busy=%b expected 0 1 1",
                         ram_we, wr_ready, busy);
            end
            @(posedge clk);
            #1;
        end
        bad = 0;
        for (int b = 0; b <= int'(l); b++) begin
            ea       = a + b[5:0];
            wr_valid = 1'b1;
            wr_data  = vec[b];
            @(negedge clk);
            if (wr_ready !== 1'b1 || ram_we !== 1'b1 || ram_addr !== ea ||
                ram_data_in !== vec[b] || cmd_ready !== 1'b0) bad++;
            @(posedge clk);
            #1;
        end
        wr_valid = 1'b0;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL write_beats: got %0d bad beats expected 0 (addr %0d len %0d)", bad, a, l);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL write_done: got busy=%b cmd_ready=%b expected 0 1", busy, cmd_ready);
        end
        bad = 0;
        for (int b = 0; b <= int'(l); b++) begin
            ea = a + b[5:0];
            if (mem[ea] !== vec[b]) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL write_mem: got %0d wrong locations expected 0 (addr %0d len %0d)", bad, a, l);
        end
    endtask

    task automatic test_read(input logic [5:0] a, input logic [5:0] l,
                             input int stall_beat, input int stall_n);
        int beat;
        int cyc;
        int first;
        int bad;
        int gaps;
        int hold_bad;
        logic stalled;
        do_cmd(1'b0, a, l);
        rd_ready = 1'b1;
        beat     = 0;
        cyc      = 0;
        first    = -1;
        bad      = 0;
        gaps     = 0;
        hold_bad = 0;
        stalled  = 1'b0;
        while (beat <= int'(l) && cyc < 300) begin
            @(negedge clk);
            cyc++;
            if (rd_valid !== 1'b1) begin
                if (beat > 0) gaps++;
            end else begin
                if (first < 0) first = cyc;
                if (!stalled && stall_n > 0 && beat == stall_beat) begin
                    stalled  = 1'b1;
                    rd_ready = 1'b0;
                    for (int s = 0; s < stall_n; s++) begin
                        #1;
                        if (rd_valid !== 1'b1 || rd_data !== vec[beat]) hold_bad++;
                        @(negedge clk);
                        cyc++;
                    end
                    rd_ready = 1'b1;
                end
                if (rd_data !== vec[beat]) bad++;
                beat++;
            end
        end
        checks++;
        if (beat != int'(l) + 1) begin
            errors++;
            $display("FAIL read_count: got %0d beats expected %0d", beat, int'(l) + 1);
        end
        checks++;
        if (bad != 0 || hold_bad != 0) begin
            errors++;
            $display("FAIL read_data: got %0d bad beats and %0d unstable stall cycles expected 0 0",
                     bad, hold_bad);
        end
        checks++;
        if (gaps != 0 || first != 2) begin
            errors++;
            $display("FAIL read_timing: got gaps=%0d first_valid_cycle=%0d expected 0 2", gaps, first);
        end
        @(negedge clk);
        checks++;
        if (rd_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL read_done: got rd_valid=%b busy=%b expected 0 0", rd_valid, busy);
        end
    endtask

    task automatic test_reset_mid_burst();
        for (int i = 0; i < 8; i++) vec[i] = 6'(i + 7);
        do_cmd(1'b1, 6'd10, 6'd7);
        for (int b = 0; b < 2; b++) begin
            wr_valid = 1'b1;
            wr_data  = vec[b];
            @(posedge clk);
            #1;
        end
        wr_data = vec[2];
        rst_n   = 1'b0;
        #1;
        checks++;
        if (ram_we !== 1'b0 || busy !== 1'b1 || wr_ready !== 1'b0 || init_done !== 1'b0) begin
            errors++;
            $display("FAIL abort_outputs: got we=%b busy=%b wr_ready=%b init_done=%b expected 0 1 0 0",
                     ram_we, busy, wr_ready, init_done);
        end
        repeat (3) @(posedge clk);
        #1;
        wr_valid = 1'b0;
        checks++;
        if (mem[10] !== vec[0] || mem[11] !== vec[1] || mem[12] !== 6'd0) begin
            errors++;
            $display("FAIL abort_mem: got %0d %0d %0d expected %0d %0d 0",
                     mem[10], mem[11], mem[12], vec[0], vec[1]);
        end
        test_init();
        for (int i = 0; i < 64; i++) vec[i] = 6'd0;
        test_read(6'd0, 6'd63, 0, 0);
    endtask

    initial begin
        test_reset();
        test_init();

        vec[0] = 6'd11; vec[1] = 6'd22; vec[2] = 6'd33; vec[3] = 6'd44;
        test_write(6'd5, 6'd3, 1'b0);
        test_read(6'd5, 6'd3, 0, 0);
        test_read(6'd5, 6'd3, 1, 3);

        vec[0] = 6'd1; vec[1] = 6'd2; vec[2] = 6'd3; vec[3] = 6'd4;
        test_write(6'd62, 6'd3, 1'b1);
        test_read(6'd62, 6'd3, 0, 0);

        test_reset_mid_burst();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded 200000 ns");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/ram_burst_ctrl.md
RAM_BURST_CTRL -- requirements
Module: ram_burst_ctrl

Interface
REQ-001 Parameter addr_width, default 6, RAM address width; memory depth is 2**addr_width.
REQ-002 Parameter data_width, default 6, RAM data width.
REQ-003 clk  input  1  the single clock; all state SHALL update on posedge clk.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 cmd_valid / cmd_ready  input / output  1 / 1  burst command handshake.
REQ-006 cmd_write  input  1  1 = write burst, 0 = read burst.
REQ-007 cmd_addr  input  addr_width  first beat address.
REQ-008 cmd_len  input  addr_width  beat count minus one (0 = 1 beat).
REQ-009 wr_valid / wr_ready  input / output  1 / 1  write-data handshake.
REQ-010 wr_data  input  data_width  write beat data.
REQ-011 rd_valid / rd_ready  output / input  1 / 1  read-data handshake.
REQ-012 rd_data  output  data_width  read beat data.
REQ-013 busy  output  1  high in any state other than IDLE.
REQ-014 init_done  output  1  high once the post-reset clear has completed.
REQ-015 ram_we, ram_addr, ram_data_in  output  1, addr_width, data_width  drive the RAM's we, addr, data_in.
REQ-016 ram_data_out  input  data_width  RAM data_out; value of the address the RAM registered on the previous edge.

Function
REQ-017 The FSM SHALL have states INIT, IDLE, WRITE and READ.
REQ-018 INIT SHALL write 0 to addresses 0..2**addr_width-1, one address per cycle with ram_we=1, then enter IDLE and set init_done=1.
REQ-019 cmd_ready SHALL be 1 only in IDLE; a command SHALL be accepted on a cycle where cmd_valid and cmd_ready are both 1.
REQ-020 On acceptance the block SHALL latch address and length, then enter WRITE if cmd_write=1, otherwise READ.
REQ-021 WRITE SHALL behave as follows:
- wr_ready=1 throughout the state.
- On each wr_valid&&wr_ready cycle: ram_we=1, ram_addr=current address, ram_data_in=wr_data.
- The address increments after each beat.
- After beat cmd_len+1 the FSM returns to IDLE.
REQ-022 ram_we SHALL be 0 in WRITE cycles where wr_valid=0, in READ, and in IDLE.
REQ-023 READ SHALL behave as follows:
- ram_addr presents the address of the beat to be shown after the next edge.
- rd_data = ram_data_out.
- rd_valid=1 from the cycle after READ entry until the last beat is accepted.
- Throughput is one beat per cycle while rd_ready=1.
REQ-024 When rd_valid=1 and rd_ready=0, ram_addr SHALL hold the current beat address, so rd_data stays stable.
REQ-025 After the beat cmd_len+1 handshake, the FSM SHALL return to IDLE with rd_valid=0 on the next cycle.
REQ-026 Burst addresses SHALL wrap modulo 2**addr_width; for example, addr 62 with len 3 covers 62, 63, 0, 1.
REQ-027 The beat counter SHALL be addr_width+1 bits wide, so cmd_len = 2**addr_width-1 produces a full-depth burst without overflow.
REQ-028 cmd_valid while busy SHALL be ignored (not queued); it is accepted only after the return to IDLE.

Reset
REQ-029 While rst_n=0, outputs SHALL be:
- ram_we=0, ram_addr=0, ram_data_in=0.
- cmd_ready=0, wr_ready=0, rd_valid=0.
- busy=1, init_done=0.
REQ-030 Deassertion of rst_n SHALL start INIT at address 0.
REQ-031 Reset asserted mid-burst SHALL abort the burst immediately; no further RAM writes occur until INIT restarts, and the full clear is repeated.

Structure
REQ-032 A shared package ram_pkg SHALL hold the FSM state type and the default width constants.
REQ-033 An address/beat counter sub-module ram_addr_gen (load, increment, wrap, last-beat flag) SHALL be instantiated by ram_burst_ctrl and shared by the INIT, WRITE and READ states.

Verification
REQ-034 Reset with default params -> exactly 64 cycles of ram_we=1 covering addr 0..63 with data 0, then init_done=1, cmd_ready=1.
REQ-035 Write addr 5 len 3 with data 11,22,33,44 and continuous wr_valid -> RAM[5..8] = 11,22,33,44; busy drops after 4 beats.
REQ-036 Read addr 5 len 3 with rd_ready held 1 -> rd_data 11,22,33,44 on 4 consecutive rd_valid cycles.
REQ-037 Same read with rd_ready low on beat 2 for 3 cycles -> rd_data holds 22 stable, no beat lost or duplicated.
REQ-038 Write addr 62 len 3 with data 1,2,3,4 -> RAM[62]=1, RAM[63]=2, RAM[0]=3, RAM[1]=4.
REQ-039 Assert rst_n=0 after beat 2 of an 8-beat write -> ram_we drops immediately, INIT reruns, and all 64 locations read back 0.
